stream_sink: RTL and testbench

STREAM_SINK -- requirements
Module: stream_sink

---
 rtl/stream_sink_pkg.sv | 21 ++
 rtl/stream_sink_fifo.sv | 55 +++++
 rtl/stream_sink.sv | 163 ++++++++++++++++
 tb/tb_stream_sink.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_sink_pkg.sv
// Shared types and constants for the stream_sink byte sink.
package stream_sink_pkg;

   localparam int BYTE_W        = 8;
   localparam int CNT_W         = 8;
   localparam int DEPTH_DEFAULT = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } frame_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) r = v;
      else                    r = v + {{(CNT_W-1){1'b0}}, 1'b1};
      return r;
   endfunction

endpackage

// File: rtl/stream_sink_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO, power-of-two depth.
// Push while full and pop while empty are ignored.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   // Count never exceeds DEPTH, so its MSB alone marks the full condition.
   assign full    = count_q[AW];
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Pointers wrap naturally at AW bits; count tracks the occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
         if (do_pop)  rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_q <= count_q - {{AW{1'b0}}, 1'b1};
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array, not reset; contents are only visible through the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/stream_sink.sv
// stream_sink: AXI-stream byte sink with FIFO storage, frame statistics and
// an optional incrementing-pattern checker enabled by STREAM_SINK_CHECK_EN.
//
// state  | meaning
// IDLE   | between frames; next accepted beat is index 0 of a new frame
// ACTIVE | inside a frame; at least one non-last beat accepted
module stream_sink
   import stream_sink_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [BYTE_W-1:0]         s_axis_tdata,
   input  logic                      s_axis_tvalid,
   input  logic                      s_axis_tlast,
   output logic                      s_axis_tready,
   input  logic                      stall,
   input  logic                      pop,
   output logic [BYTE_W-1:0]         dout,
   output logic [$clog2(DEPTH):0]    buff_count,
   output logic                      empty,
   output logic                      full,
   output logic                      frame_done,
   output logic [CNT_W-1:0]          last_frame_len,
   output logic [CNT_W-1:0]          frame_count,
   input  logic [BYTE_W-1:0]         seed,
   input  logic                      clear_err,
   output logic [CNT_W-1:0]          mismatch_count,
   output logic                      error
);

   frame_state_e     state_q, state_d;
   logic             frame_start;
   logic             accept;
   logic [CNT_W-1:0] len_q, len_d, len_base, len_inc;
   logic [CNT_W-1:0] last_len_q, last_len_d;
   logic [CNT_W-1:0] fcount_q, fcount_d;
   logic             done_q, done_d;

   assign s_axis_tready = !full && !stall;
   assign accept        = s_axis_tvalid && s_axis_tready;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (BYTE_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .din   (s_axis_tdata),
      .pop   (pop),
      .dout  (dout),
      .count (buff_count),
      .empty (empty),
      .full  (full)
   );

   // Frame state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // A single tlast beat from IDLE keeps the FSM in IDLE.
   always_comb begin
      state_d = state_q;
      if (accept) state_d = s_axis_tlast ? IDLE : ACTIVE;
   end

   // Decoded FSM outputs.
   always_comb begin
      frame_start = (state_q == IDLE);
   end

   // Frame length / statistics next-state.
   always_comb begin
      len_base   = frame_start ? '0 : len_q;
      len_inc    = sat_inc(len_base);
      len_d      = len_q;
      last_len_d = last_len_q;
      fcount_d   = fcount_q;
      done_d     = 1'b0;
      if (accept) begin
         if (s_axis_tlast) begin
            len_d      = '0;
            last_len_d = len_inc;
            fcount_d   = fcount_q + {{(CNT_W-1){1'b0}}, 1'b1};
            done_d     = 1'b1;
         end else begin
            len_d      = len_inc;
         end
      end
   end

   // Frame statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q      <= '0;
         last_len_q <= '0;
         fcount_q   <= '0;
         done_q     <= 1'b0;
      end else begin
         len_q      <= len_d;
         last_len_q <= last_len_d;
         fcount_q   <= fcount_d;
         done_q     <= done_d;
      end
   end

   assign frame_done     = done_q;
   assign last_frame_len = last_len_q;
   assign frame_count    = fcount_q;

`ifdef STREAM_SINK_CHECK_EN
   // Index wraps at 256 independently of the saturating length counter.
   logic [BYTE_W-1:0] idx_q, idx_d, idx_base;
   logic [CNT_W-1:0]  mm_q, mm_d;
   logic              err_q, err_d;
   logic              mismatch;

   assign idx_base = frame_start ? '0 : idx_q;
   assign mismatch = accept && (s_axis_tdata != (seed + idx_base));

   // Checker next-state; a same-cycle mismatch wins over clear_err.
   always_comb begin
      idx_d = idx_q;
      mm_d  = mm_q;
      err_d = err_q;
      if (accept) idx_d = s_axis_tlast ? '0 : idx_base + {{(BYTE_W-1){1'b0}}, 1'b1};
      if (clear_err) begin
         mm_d  = '0;
         err_d = 1'b0;
      end
      if (mismatch) begin
         mm_d  = sat_inc(mm_d);
         err_d = 1'b1;
      end
   end

   // Checker registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         mm_q  <= '0;
         err_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         mm_q  <= mm_d;
         err_q <= err_d;
      end
   end

   assign mismatch_count = mm_q;
   assign error          = err_q;
`else
   logic unused_cfg;
   assign unused_cfg     = ^{seed, clear_err};
   assign mismatch_count = '0;
   assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_stream_sink.sv
module tb_stream_sink;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s_axis_tdata;
   logic       s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic       stall, pop;
   logic [7:0] dout;
   logic [4:0] buff_count;
   logic       empty, full, frame_done;
   logic [7:0] last_frame_len, frame_count;
   logic [7:0] seed;
   logic       clear_err;
   logic [7:0] mismatch_count;
   logic       error;

   stream_sink #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .stall(stall), .pop(pop), .dout(dout), .buff_count(buff_count),
      .empty(empty), .full(full), .frame_done(frame_done),
      .last_frame_len(last_frame_len), .frame_count(frame_count),
      .seed(seed), .clear_err(clear_err),
      .mismatch_count(mismatch_count), .error(error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

`ifdef STREAM_SINK_CHECK_EN
   localparam bit CHECK_ON = 1'b1;
`else
   localparam bit CHECK_ON = 1'b0;
`endif

   // ---------------- behavioural model ----------------
   byte unsigned m_q[$];
   int  m_beats = 0;
   int  m_last_len = 0;
   int  m_fcount = 0;
   int  m_mm = 0;
   bit  m_err = 0;
   bit  m_done = 0;
   bit  model_ok = 0;

   always @(posedge clk) begin
      bit acc, dpop;
      if (rst) begin
         m_q.delete();
         m_beats = 0; m_last_len = 0; m_fcount = 0;
         m_mm = 0; m_err = 0; m_done = 0;
         model_ok = 1;
      end else begin
         acc  = s_axis_tvalid && (m_q.size() < DEPTH) && !stall;
         dpop = pop && (m_q.size() > 0);
         m_done = 0;
         if (CHECK_ON && clear_err) begin
            m_mm = 0; m_err = 0;
         end
         if (acc) begin
            if (CHECK_ON && (s_axis_tdata != 8'((int'(seed) + m_beats) % 256))) begin
               m_mm = (m_mm < 255) ? m_mm + 1 : 255;
               m_err = 1;
            end
            m_beats++;
            if (s_axis_tlast) begin
               m_done = 1;
               m_last_len = (m_beats > 255) ? 255 : m_beats;
               m_fcount = (m_fcount + 1) % 256;
               m_beats = 0;
            end
         end
         if (dpop) void'(m_q.pop_front());
         if (acc) m_q.push_back(s_axis_tdata);
      end
   end

   // ---------------- per-cycle compare ----------------
   int   pulses = 0;
   int   max_count = 0;
   bit   rec_en = 0;
   byte unsigned popped[$];

   always @(negedge clk) begin
      if (model_ok) begin
         chk("buff_count", buff_count, m_q.size());
         chk("empty", empty, m_q.size() == 0);
         chk("full", full, m_q.size() == DEPTH);
         chk("tready", s_axis_tready, (m_q.size() != DEPTH) && !stall);
         chk("frame_done", frame_done, m_done);
         chk("last_frame_len", last_frame_len, m_last_len);
         chk("frame_count", frame_count, m_fcount);
         chk("mismatch_count", mismatch_count, m_mm);
         chk("error", error, m_err);
         if (m_q.size() > 0) chk("dout", dout, m_q[0]);
         if (frame_done === 1'b1) pulses++;
         if (int'(buff_count) > max_count) max_count = int'(buff_count);
         if (rec_en && pop && !empty) popped.push_back(dout);
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_in(input bit v, input byte unsigned d, input bit l,
                         input bit p, input bit s, input bit c);
      s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l;
      pop = p; stall = s; clear_err = c;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0, 0, 0);
      rst = 1; step(); step();
      rst = 0; step();
   endtask

   byte unsigned pushed[$];

   initial begin
      rst = 1; seed = 8'h10;
      set_in(0, 0, 0, 0, 0, 0);
      step(); step();
      rst = 0;
      settle();
      chk("rst_buff_count", buff_count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_error", error, 0);

      // Three-beat frame matching the seed pattern.
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         set_in(1, 8'(8'h10 + i), i == 2, 0, 0, 0); step();
      end
      set_in(0, 0, 0, 0, 0, 0); step(); step(); settle();
      chk("f3_buff_count", buff_count, 3);
      chk("f3_pulses", pulses, 1);
      chk("f3_last_len", last_frame_len, 3);
      chk("f3_frame_count", frame_count, 1);
      chk("f3_error", error, 0);
      chk("f3_dout", dout, 8'h10);

      // Fill to full, then free one slot.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         set_in(1, 8'(8'hA0 + i), 0, 0, 0, 0); step();
      end
      set_in(1, 8'hEE, 0, 0, 0, 0); step();
      set_in(0, 0, 0, 0, 0, 0); settle();
      chk("full_flag", full, 1);
      chk("full_tready", s_axis_tready, 0);
      chk("full_count", buff_count, 16);
      set_in(0, 0, 0, 1, 0, 0); step();
      set_in(0, 0, 0, 0, 0, 0); settle();
      chk("pop1_count", buff_count, 15);
      chk("pop1_tready", s_axis_tready, 1);
      chk("pop1_dout", dout, 8'hA1);

      // Streaming with continuous pop across pointer wrap.
      do_reset();
      pushed.delete(); popped.delete(); max_count = 0;
      rec_en = 1;
      for (int i = 0; i < 40; i++) begin
         pushed.push_back(8'($urandom_range(0, 255)));
         set_in(1, pushed[i], 0, 1, 0, 0); step();
      end
      for (int i = 0; i < 4; i++) begin
         set_in(0, 0, 0, 1, 0, 0); step();
      end
      set_in(0, 0, 0, 0, 0, 0); settle();
      rec_en = 0;
      chk("wrap_popped_n", popped.size(), 40);
      for (int i = 0; i < 40 && i < popped.size(); i++)
         chk("wrap_byte", popped[i], pushed[i]);
      chk("wrap_max_le16", max_count <= 16, 1);
      chk("wrap_empty", empty, 1);

      // Single-beat frames; 256 of them wrap frame_count to zero.
      do_reset();
      seed = 8'h10;
      for (int k = 0; k < 256; k++) begin
         set_in(1, 8'h10, 1, 1, 0, 0); step();
         if (k == 0) begin
            settle();
            chk("single_len", last_frame_len, 1);
            chk("single_fc", frame_count, 1);
         end
      end
      set_in(0, 0, 0, 0, 0, 0); step(); settle();
      chk("single256_fc", frame_count, 0);
      chk("single256_len", last_frame_len, 1);

      // Pattern checker: one bad byte, clear, then clear vs mismatch.
      do_reset();
      seed = 8'h10;
      set_in(1, 8'h10, 0, 1, 0, 0); step();
      set_in(1, 8'h99, 0, 1, 0, 0); step();
      set_in(1, 8'h12, 1, 1, 0, 0); step();
      set_in(0, 0, 0, 0, 0, 0); settle();
      chk("cmp_mm", mismatch_count, CHECK_ON ? 1 : 0);
      chk("cmp_err", error, CHECK_ON ? 1 : 0);
      set_in(0, 0, 0, 0, 0, 1); step();
      set_in(0, 0, 0, 0, 0, 0); settle();
      chk("clr_mm", mismatch_count, 0);
      chk("clr_err", error, 0);
      set_in(1, 8'h77, 1, 1, 0, 0); step();
      set_in(1, 8'h55, 1, 1, 0, 1); step();
      set_in(0, 0, 0, 0, 0, 0); settle();
      chk("clrwin_mm", mismatch_count, CHECK_ON ? 1 : 0);
      chk("clrwin_err", error, CHECK_ON ? 1 : 0);

      // Stall blocks acceptance; reset mid-frame discards the partial frame.
      do_reset();
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         set_in(1, 8'h10, 0, 0, 1, 0); step();
      end
      settle();
      chk("stall_count", buff_count, 0);
      chk("stall_tready", s_axis_tready, 0);
      set_in(1, 8'h10, 0, 0, 0, 0); step();
      set_in(1, 8'h11, 0, 0, 0, 0); step();
      set_in(0, 0, 0, 0, 0, 0);
      rst = 1; step(); step();
      rst = 0; step(); step(); settle();
      chk("mrst_count", buff_count, 0);
      chk("mrst_empty", empty, 1);
      chk("mrst_len", last_frame_len, 0);
      chk("mrst_fc", frame_count, 0);
      chk("mrst_pulses", pulses, 0);
      set_in(1, 8'h10, 0, 0, 0, 0); step();
      set_in(1, 8'h11, 1, 0, 0, 0); step();
      set_in(0, 0, 0, 0, 0, 0); settle();
      chk("after_rst_len", last_frame_len, 2);
      chk("after_rst_err", error, 0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         bit v, l, p, s, c;
         byte unsigned d;
         v = ($urandom_range(0, 3) != 0);
         l = ($urandom_range(0, 5) == 0);
         p = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
         s = ($urandom_range(0, 4) == 0);
         c = ($urandom_range(0, 19) == 0);
         d = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'((int'(seed) + m_beats) % 256);
         if ($urandom_range(0, 99) == 0) seed = 8'($urandom_range(0, 255));
         set_in(v, d, l, p, s, c);
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 0;
      set_in(0, 0, 0, 0, 0, 0); step(); settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
